// File: rtl/mnist_cnn_axil_slave.sv
// AXI4-Lite slave exposing four 32-bit control registers to the MNIST CNN core.
// Optional: define MNIST_AXIL_DECERR_EN to answer unmapped accesses with SLVERR.
module mnist_cnn_axil_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                              S_AXI_ACLK,
  input  logic                              S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [2:0]                        S_AXI_ARPROT,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     slv_reg0,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     slv_reg1,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     slv_reg2,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     slv_reg3,
  output logic [3:0]                        reg_wr_pulse
);

  localparam int NBYTES = C_S_AXI_DATA_WIDTH / 8;
  localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef MNIST_AXIL_DECERR_EN
  localparam logic [1:0] RESP_UNMAPPED = 2'b10;
`else
  localparam logic [1:0] RESP_UNMAPPED = 2'b00;
`endif

  // Write-path flags (aw_held, w_held, bvalid) folded into one state;
  // both held flags are always clear while the response is pending.
  typedef enum logic [2:0] {
    WR_IDLE,
    WR_AW,
    WR_W,
    WR_BOTH,
    WR_RESP
  } wr_state_e;

  wr_state_e wr_state_q, wr_state_d;

  logic                          rdy_en_q;
  logic [C_S_AXI_ADDR_WIDTH-1:0] awaddr_q;
  logic [C_S_AXI_DATA_WIDTH-1:0] wdata_q;
  logic [NBYTES-1:0]             wstrb_q;
  logic [1:0]                    bresp_q;
  logic [3:0]                    pulse_q;
  logic [C_S_AXI_DATA_WIDTH-1:0] slv_q [4];
  logic                          rvalid_q;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q;
  logic [1:0]                    rresp_q;

  logic       awready, wready, commit, bvalid;
  logic       aw_hs, w_hs, ar_hs;
  logic       aw_unmapped, ar_unmapped;
  logic [1:0] aw_sel, ar_sel;
  logic       unused_prot;

  assign unused_prot = ^{S_AXI_AWPROT, S_AXI_ARPROT};

  assign aw_sel      = awaddr_q[3:2];
  assign ar_sel      = S_AXI_ARADDR[3:2];
  assign aw_unmapped = (awaddr_q >> 4) != '0;
  assign ar_unmapped = (S_AXI_ARADDR >> 4) != '0;

  assign aw_hs = S_AXI_AWVALID && awready;
  assign w_hs  = S_AXI_WVALID && wready;
  assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) wr_state_q <= WR_IDLE;
    else                wr_state_q <= wr_state_d;
  end

  always_comb begin
    wr_state_d = wr_state_q;
    case (wr_state_q)
      WR_IDLE: begin
        if (aw_hs && w_hs) wr_state_d = WR_BOTH;
        else if (aw_hs)    wr_state_d = WR_AW;
        else if (w_hs)     wr_state_d = WR_W;
      end
      WR_AW:   if (w_hs) wr_state_d = WR_BOTH;
      WR_W:    if (aw_hs) wr_state_d = WR_BOTH;
      WR_BOTH: wr_state_d = WR_RESP;
      WR_RESP: if (S_AXI_BREADY) wr_state_d = WR_IDLE;
      default: wr_state_d = WR_IDLE;
    endcase
  end

  always_comb begin
    awready = rdy_en_q && (wr_state_q == WR_IDLE || wr_state_q == WR_W);
    wready  = rdy_en_q && (wr_state_q == WR_IDLE || wr_state_q == WR_AW);
    commit  = (wr_state_q == WR_BOTH);
    bvalid  = (wr_state_q == WR_RESP);
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      rdy_en_q <= 1'b0;
      awaddr_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      bresp_q  <= RESP_OKAY;
      pulse_q  <= '0;
      for (int unsigned i = 0; i < 4; i++) slv_q[i] <= '0;
    end else begin
      rdy_en_q <= 1'b1;
      if (aw_hs) awaddr_q <= S_AXI_AWADDR;
      if (w_hs) begin
        wdata_q <= S_AXI_WDATA;
        wstrb_q <= S_AXI_WSTRB;
      end
      pulse_q <= (commit && !aw_unmapped) ? (4'b0001 << aw_sel) : '0;
      if (commit) begin
        bresp_q <= aw_unmapped ? RESP_UNMAPPED : RESP_OKAY;
        if (!aw_unmapped) begin
          for (int unsigned k = 0; k < NBYTES; k++) begin
            if (wstrb_q[k]) slv_q[aw_sel][8*k +: 8] <= wdata_q[8*k +: 8];
          end
        end
      end
    end
  end

  // Nonblocking read of slv_q returns the pre-commit value on a same-edge write.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
    end else if (ar_hs) begin
      rvalid_q <= 1'b1;
      rdata_q  <= ar_unmapped ? '0 : slv_q[ar_sel];
      rresp_q  <= ar_unmapped ? RESP_UNMAPPED : RESP_OKAY;
    end else if (rvalid_q && S_AXI_RREADY) begin
      rvalid_q <= 1'b0;
    end
  end

  assign S_AXI_AWREADY = awready;
  assign S_AXI_WREADY  = wready;
  assign S_AXI_BVALID  = bvalid;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = rdy_en_q && !rvalid_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;
  assign slv_reg0      = slv_q[0];
  assign slv_reg1      = slv_q[1];
  assign slv_reg2      = slv_q[2];
  assign slv_reg3      = slv_q[3];
  assign reg_wr_pulse  = pulse_q;

endmodule

// File: tb/tb_mnist_cnn_axil_slave.sv
// Self-checking bench for mnist_cnn_axil_slave (6-bit address so 0x10+ is unmapped).
module tb_mnist_cnn_axil_slave;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic [31:0] reg0, reg1, reg2, reg3;
  logic [3:0]  pulse_o;

  always #5 clk = ~clk;

  mnist_cnn_axil_slave #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(6)
  ) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .slv_reg0(reg0), .slv_reg1(reg1), .slv_reg2(reg2), .slv_reg3(reg3),
    .reg_wr_pulse(pulse_o)
  );

`ifdef MNIST_AXIL_DECERR_EN
  localparam logic [1:0] UNMAP_RESP = 2'b10;
`else
  localparam logic [1:0] UNMAP_RESP = 2'b00;
`endif

  int total = 0;
  int bad   = 0;
  logic [31:0] mdl [4];

  typedef struct {
    logic [5:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          aw_dly;
    int          w_dly;
    logic [3:0]  exp_pulse;
    logic [1:0]  exp_bresp;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void mdl_write(input logic [5:0] addr, input logic [31:0] data,
                                    input logic [3:0] strb, output logic [1:0] resp,
                                    output logic [3:0] pulse);
    logic [31:0] mask;
    int idx;
    for (int k = 0; k < 4; k++) mask[8*k +: 8] = {8{strb[k]}};
    idx = int'(addr) / 4;
    if (addr >= 6'd16) begin
      resp  = UNMAP_RESP;
      pulse = 4'b0000;
    end else begin
      mdl[idx] = (mdl[idx] & ~mask) | (data & mask);
      resp  = 2'b00;
      pulse = 4'(1 << idx);
    end
  endfunction

  function automatic logic [31:0] mdl_read(input logic [5:0] addr);
    return (addr >= 6'd16) ? 32'h0 : mdl[int'(addr) / 4];
  endfunction

  task automatic chk_regs(input string tag);
    chk({tag, "_reg0"}, reg0, mdl[0]);
    chk({tag, "_reg1"}, reg1, mdl[1]);
    chk({tag, "_reg2"}, reg2, mdl[2]);
    chk({tag, "_reg3"}, reg3, mdl[3]);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_awready"}, 32'(awready), 32'd0);
    chk({tag, "_wready"},  32'(wready),  32'd0);
    chk({tag, "_arready"}, 32'(arready), 32'd0);
    chk({tag, "_bvalid"},  32'(bvalid),  32'd0);
    chk({tag, "_rvalid"},  32'(rvalid),  32'd0);
    chk({tag, "_bresp"},   32'(bresp),   32'd0);
    chk({tag, "_rresp"},   32'(rresp),   32'd0);
    chk({tag, "_rdata"},   rdata,        32'd0);
    chk({tag, "_pulse"},   32'(pulse_o), 32'd0);
    chk({tag, "_regs"},    reg0 | reg1 | reg2 | reg3, 32'd0);
  endtask

  task automatic do_write(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_dly, input int w_dly, input int bhold,
                          output logic [1:0] resp, output logic [3:0] pulse);
    logic aw_done, w_done, aw_hs, w_hs;
    int cyc;
    aw_done = 1'b0; w_done = 1'b0; cyc = 0;
    awaddr = addr; wdata = data; wstrb = strb;
    while (!(aw_done && w_done) && cyc < 64) begin
      awvalid = !aw_done && (cyc >= aw_dly);
      wvalid  = !w_done && (cyc >= w_dly);
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      @(posedge clk); #1; cyc++;
      if (aw_hs) aw_done = 1'b1;
      if (w_hs) w_done = 1'b1;
      if (w_done && !aw_done) chk("wready_after_w", 32'(wready), 32'd0);
      if (aw_done && !w_done) chk("awready_after_aw", 32'(awready), 32'd0);
    end
    awvalid = 1'b0; wvalid = 1'b0;
    chk("aw_w_accepted", 32'(aw_done && w_done), 32'd1);
    cyc = 0;
    while (!bvalid && cyc < 16) begin
      @(posedge clk); #1; cyc++;
    end
    chk("commit_latency", 32'(cyc), 32'd1);
    pulse = pulse_o;
    resp  = bresp;
    for (int i = 0; i < bhold; i++) begin
      @(posedge clk); #1;
      chk("bvalid_hold", 32'(bvalid), 32'd1);
      chk("awready_hold", 32'(awready), 32'd0);
      chk("wready_hold", 32'(wready), 32'd0);
      chk("pulse_once", 32'(pulse_o), 32'd0);
    end
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    chk("bvalid_clear", 32'(bvalid), 32'd0);
    chk("pulse_clear", 32'(pulse_o), 32'd0);
  endtask

  task automatic do_read(input logic [5:0] addr, input int rhold,
                         output logic [31:0] data, output logic [1:0] resp);
    int cyc;
    araddr = addr; arvalid = 1'b1; cyc = 0;
    while (!arready && cyc < 16) begin
      @(posedge clk); #1; cyc++;
    end
    chk("arready_seen", 32'(arready), 32'd1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    chk("rvalid_set", 32'(rvalid), 32'd1);
    chk("arready_busy", 32'(arready), 32'd0);
    data = rdata;
    resp = rresp;
    for (int i = 0; i < rhold; i++) begin
      @(posedge clk); #1;
      chk("rvalid_hold", 32'(rvalid), 32'd1);
      chk("rdata_stable", rdata, data);
      chk("rresp_stable", 32'(rresp), 32'(resp));
      chk("arready_hold", 32'(arready), 32'd0);
    end
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
    chk("rvalid_clear", 32'(rvalid), 32'd0);
    chk("arready_back", 32'(arready), 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  resp, eresp;
    logic [3:0]  pulse, epulse;
    logic [31:0] data;
    logic [5:0]  a;

    vecs[0] = '{6'h00, 32'h0000_0001, 4'hF, 0, 0, 4'b0001, 2'b00, 32'h0000_0001};
    vecs[1] = '{6'h04, 32'h0000_0002, 4'hF, 0, 0, 4'b0010, 2'b00, 32'h0000_0002};
    vecs[2] = '{6'h08, 32'h0000_0003, 4'hF, 0, 0, 4'b0100, 2'b00, 32'h0000_0003};
    vecs[3] = '{6'h0C, 32'h0000_0004, 4'hF, 0, 0, 4'b1000, 2'b00, 32'h0000_0004};
    vecs[4] = '{6'h08, 32'hDEAD_BEEF, 4'hF, 5, 0, 4'b0100, 2'b00, 32'hDEAD_BEEF};
    vecs[5] = '{6'h08, 32'hCAFE_F00D, 4'hF, 0, 5, 4'b0100, 2'b00, 32'hCAFE_F00D};
    vecs[6] = '{6'h04, 32'h1122_3344, 4'hF, 0, 0, 4'b0010, 2'b00, 32'h1122_3344};
    vecs[7] = '{6'h04, 32'hAABB_CCDD, 4'b0101, 0, 0, 4'b0010, 2'b00, 32'h11BB_33DD};
    vecs[8] = '{6'h06, 32'h0000_00EE, 4'b0001, 1, 2, 4'b0010, 2'b00, 32'h11BB_33EE};
    vecs[9] = '{6'h0C, 32'hFFFF_FFFF, 4'b0000, 0, 0, 4'b1000, 2'b00, 32'h0000_0004};

    rst_n = 1'b0;
    awaddr = '0; awprot = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
    for (int i = 0; i < 4; i++) mdl[i] = '0;

    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;
    #1;
    chk("awready_before_edge", 32'(awready), 32'd0);
    @(posedge clk); #1;
    chk("awready_after_release", 32'(awready), 32'd1);
    chk("wready_after_release", 32'(wready), 32'd1);
    chk("arready_after_release", 32'(arready), 32'd1);

    for (int i = 0; i < 10; i++) begin
      do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].aw_dly, vecs[i].w_dly, 0, resp, pulse);
      mdl_write(vecs[i].addr, vecs[i].data, vecs[i].strb, eresp, epulse);
      chk("vec_bresp", 32'(resp), 32'(vecs[i].exp_bresp));
      chk("vec_pulse", 32'(pulse), 32'(vecs[i].exp_pulse));
      do_read(vecs[i].addr, 0, data, resp);
      chk("vec_rdata", data, vecs[i].exp_rdata);
      chk("vec_rresp", 32'(resp), 32'd0);
    end
    do_read(6'h00, 0, data, resp);
    chk("reg0_readback", data, 32'h0000_0001);

    // Backpressure on both response channels.
    do_write(6'h0C, 32'h0BAD_F00D, 4'hF, 0, 0, 10, resp, pulse);
    mdl_write(6'h0C, 32'h0BAD_F00D, 4'hF, eresp, epulse);
    chk("bp_bresp", 32'(resp), 32'd0);
    do_read(6'h0C, 6, data, resp);
    chk("bp_rdata", data, 32'h0BAD_F00D);

    // AR handshake on the same edge as a commit to reg0 (old value 0x1).
    awaddr = 6'h00; wdata = 32'h55; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    araddr = 6'h00; arvalid = 1'b1;
    @(posedge clk); #1;
    arvalid = 1'b0;
    chk("hazard_bvalid", 32'(bvalid), 32'd1);
    chk("hazard_pulse", 32'(pulse_o), 32'b0001);
    chk("hazard_rvalid", 32'(rvalid), 32'd1);
    chk("hazard_old_data", rdata, 32'h0000_0001);
    bready = 1'b1; rready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0; rready = 1'b0;
    mdl_write(6'h00, 32'h55, 4'hF, eresp, epulse);
    do_read(6'h00, 0, data, resp);
    chk("hazard_new_data", data, 32'h0000_0055);

    // Unmapped accesses.
    do_write(6'h10, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, resp, pulse);
    mdl_write(6'h10, 32'hFFFF_FFFF, 4'hF, eresp, epulse);
    chk("unmap_bresp", 32'(resp), 32'(eresp));
    chk("unmap_pulse", 32'(pulse), 32'd0);
    chk_regs("unmap_w");
    do_read(6'h10, 0, data, resp);
    chk("unmap_rdata", data, 32'd0);
    chk("unmap_rresp", 32'(resp), 32'(UNMAP_RESP));
    do_read(6'h3C, 1, data, resp);
    chk("unmap_hi_rdata", data, 32'd0);
    chk("unmap_hi_rresp", 32'(resp), 32'(UNMAP_RESP));

    // Randomized traffic against the reference model.
    for (int n = 0; n < 80; n++) begin
      a = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 3) != 0) a = a & 6'h0F;
      if ($urandom_range(0, 1) == 0) begin
        data = $urandom;
        pulse = 4'($urandom_range(0, 15));
        do_write(a, data, pulse, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 0, resp, epulse);
        mdl_write(a, data, pulse, eresp, pulse);
        chk("rnd_bresp", 32'(resp), 32'(eresp));
        chk("rnd_pulse", 32'(epulse), 32'(pulse));
        chk_regs("rnd_w");
      end else begin
        do_read(a, int'($urandom_range(0, 2)), data, resp);
        chk("rnd_rdata", data, mdl_read(a));
        chk("rnd_rresp", 32'(resp), (a >= 6'd16) ? 32'(UNMAP_RESP) : 32'd0);
      end
    end

    // Reset after only the AW handshake: partial write is discarded.
    awaddr = 6'h04; awvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    for (int i = 0; i < 4; i++) mdl[i] = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    wdata = 32'h1234_5678; wstrb = 4'hF; wvalid = 1'b1;
    @(posedge clk); #1;
    wvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("midreset_no_bvalid", 32'(bvalid), 32'd0);
      chk("midreset_no_pulse", 32'(pulse_o), 32'd0);
    end
    chk_regs("midreset");
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_write(6'h08, 32'h0000_00A5, 4'b0001, 0, 0, 0, resp, pulse);
    mdl_write(6'h08, 32'h0000_00A5, 4'b0001, eresp, epulse);
    chk("post_reset_pulse", 32'(pulse), 32'b0100);
    chk_regs("post_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
